// File: rtl/ascon_pack.sv
// ============================================================================
// Module      : ascon_pack (package)
// Description : Shared ASCON types and helpers: the 320-bit state type, the
//               decryption FSM encoding, the padding byte and a byte mask
//               helper. Word 0 of type_state is the 64-bit rate word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pack;

    // Five 64-bit words; element [0] is the rate word S[0].
    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        PERM     = 2'd2,
        DONE     = 2'd3
    } type_dec_fsm;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Mask with the top 8*l bits set (l = 0..7).
    function automatic logic [63:0] byte_mask(input logic [2:0] l);
        logic [63:0] ones;
        ones = '1;
        return ~(ones >> {l, 3'b000});
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_decrypt_block_pad.sv
// ============================================================================
// Module      : dec_pad_mask
// Description : Combinational final-block handling for ASCON-128 decryption.
//               Produces the truncated plaintext and the padded rate word.
// Ports       : rate          in  64  current rate word S[0]
//               cipher        in  64  ciphertext block C
//               nbytes        in  3   valid bytes l in the final block
//               plain_masked  out 64  top 8l bits of S[0]^C, rest zero
//               rate_padded   out 64  top 8l bits of C, rest of S[0], with
//                                     pad bit 63-8l inverted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_pad_mask
    import ascon_pack::*;
(
    input  logic [63:0] rate,
    input  logic [63:0] cipher,
    input  logic [2:0]  nbytes,
    output logic [63:0] plain_masked,
    output logic [63:0] rate_padded
);

    logic [63:0] w_mask;
    logic [63:0] w_pad;

    assign w_mask = byte_mask(nbytes);
    // Pad byte lands at byte position l; it is XORed into the state.
    assign w_pad  = {PAD_BYTE, 56'd0} >> {nbytes, 3'b000};

    assign plain_masked = (rate ^ cipher) & w_mask;
    assign rate_padded  = ((cipher & w_mask) | (rate & ~w_mask)) ^ w_pad;

endmodule

`default_nettype wire

// File: rtl/ascon_decrypt_block.sv
// ============================================================================
// Module      : ascon_decrypt_block
// Description : ASCON-128 ciphertext-processing stage. Loads the state after
//               associated data, consumes 64-bit ciphertext blocks, emits
//               plaintext, rewrites the rate word, drives the shared p6
//               permutation between full blocks and hands the final padded
//               state to finalization.
// Ports       : clock_i, reset_i (async, active-high)
//               start_i, state_i                  message start / initial S
//               cipher_i/_valid_i/_last_i/_bytes_i, cipher_ready_o
//               plain_o/_valid_o/_last_o/_bytes_o plaintext output
//               perm_start_o, perm_state_o, perm_state_i, perm_done_i
//               done_o, state_o                   final state to finalization
// Options     : ASCON_DEC_ZEROIZE_EN - zero plain_o when not valid and clear
//               the internal state on the cycle after done_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_decrypt_block
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  type_state   state_i,
    input  logic [63:0] cipher_i,
    input  logic        cipher_valid_i,
    input  logic        cipher_last_i,
    input  logic [2:0]  cipher_bytes_i,
    output logic        cipher_ready_o,
    output logic [63:0] plain_o,
    output logic        plain_valid_o,
    output logic        plain_last_o,
    output logic [2:0]  plain_bytes_o,
    output logic        perm_start_o,
    output type_state   perm_state_o,
    input  type_state   perm_state_i,
    input  logic        perm_done_i,
    output logic        done_o,
    output type_state   state_o
);

    type_dec_fsm r_fsm;
    type_dec_fsm w_fsm_nxt;

    type_state   r_s;
    type_state   r_state_out;
    logic [63:0] r_plain;
    logic        r_plain_valid;
    logic        r_plain_last;
    logic [2:0]  r_plain_bytes;
    logic        r_perm_start;

    logic [63:0] w_plain_masked;
    logic [63:0] w_rate_padded;

    dec_pad_mask u_pad (
        .rate         (r_s[0]),
        .cipher       (cipher_i),
        .nbytes       (cipher_bytes_i),
        .plain_masked (w_plain_masked),
        .rate_padded  (w_rate_padded)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:     if (start_i) w_fsm_nxt = WAIT_BLK;
            WAIT_BLK: if (cipher_valid_i) w_fsm_nxt = cipher_last_i ? DONE : PERM;
            PERM:     if (perm_done_i) w_fsm_nxt = WAIT_BLK;
            DONE:     w_fsm_nxt = IDLE;
            default:  w_fsm_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        cipher_ready_o = 1'b0;
        done_o         = 1'b0;
        case (r_fsm)
            WAIT_BLK: cipher_ready_o = 1'b1;
            DONE:     done_o         = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_s           <= '0;
            r_state_out   <= '0;
            r_plain       <= '0;
            r_plain_valid <= 1'b0;
            r_plain_last  <= 1'b0;
            r_plain_bytes <= 3'd0;
            r_perm_start  <= 1'b0;
        end else begin
            r_plain_valid <= 1'b0;
            r_perm_start  <= 1'b0;
`ifdef ASCON_DEC_ZEROIZE_EN
            // Overridden below on a block handshake.
            r_plain       <= '0;
`endif
            case (r_fsm)
                IDLE: begin
                    if (start_i) begin
                        r_s <= state_i;
                    end
                end
                WAIT_BLK: begin
                    if (cipher_valid_i) begin
                        r_plain_valid <= 1'b1;
                        r_plain_last  <= cipher_last_i;
                        if (cipher_last_i) begin
                            r_plain       <= w_plain_masked;
                            r_plain_bytes <= cipher_bytes_i;
                            r_s[0]        <= w_rate_padded;
                            r_state_out   <= {r_s[4:1], w_rate_padded};
                        end else begin
                            r_plain       <= r_s[0] ^ cipher_i;
                            r_plain_bytes <= 3'd0;
                            r_s[0]        <= cipher_i;
                            // Issued together with entering PERM so the
                            // request lands in PERM's first cycle.
                            r_perm_start  <= 1'b1;
                        end
                    end
                end
                PERM: begin
                    if (perm_done_i) begin
                        r_s <= perm_state_i;
                    end
                end
                DONE: begin
`ifdef ASCON_DEC_ZEROIZE_EN
                    r_s <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign plain_o       = r_plain;
    assign plain_valid_o = r_plain_valid;
    assign plain_last_o  = r_plain_last;
    assign plain_bytes_o = r_plain_bytes;
    assign perm_start_o  = r_perm_start;
    assign perm_state_o  = r_s;
    assign state_o       = r_state_out;

endmodule

`default_nettype wire
